// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - loads four complex operands, starts dotProduct, streams result memory out
// Optional DP_TIMEOUT_EN: abort WAIT after TIMEOUT cycles without done and pulse err.
module dot_product_sequencer #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_real,
  input  logic [WIDTH-1:0]        s_imag,
  output logic [4*WIDTH-1:0]      dp_inReal,
  output logic [4*WIDTH-1:0]      dp_inImag,
  output logic                    dp_start,
  input  logic                    dp_done,
  output logic [ADDR_WIDTH-1:0]   dp_readAddr,
  input  logic [WIDTH-1:0]        dp_readData,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [2:0] {LOAD, START, WAIT, ADDR, CAPT, OUT} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [4*WIDTH-1:0]      re_q, re_d, im_q, im_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    s_ready_q, s_ready_d;
  logic                    s_fire;
  logic                    timeout_hit;

  assign s_fire = s_valid && s_ready_q;

`ifdef DP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q;

  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT) tmo_d = tmo_q + 1'b1;
  end

  assign timeout_hit = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= timeout_hit && !dp_done;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    re_d    = re_q;
    im_d    = im_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      LOAD: begin
        if (s_fire) begin
          re_d[cnt_q*WIDTH +: WIDTH] = s_real;
          im_d[cnt_q*WIDTH +: WIDTH] = s_imag;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // done wins over a timeout expiring in the same cycle
        if (dp_done) begin
          addr_d  = '0;
          state_d = ADDR;
        end else if (timeout_hit) begin
          state_d = LOAD;
        end
      end
      ADDR: state_d = CAPT;
      CAPT: begin
        data_d  = dp_readData;
        valid_d = 1'b1;
        last_d  = (addr_q == LAST_ADDR);
        state_d = OUT;
      end
      OUT: begin
        if (m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            addr_d  = '0;
            state_d = LOAD;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    s_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      re_q      <= '0;
      im_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      re_q      <= re_d;
      im_q      <= im_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign dp_inReal   = re_q;
  assign dp_inImag   = im_q;
  assign dp_start    = (state_q == START);
  assign dp_readAddr = addr_q;
  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign m_last      = last_q;
  assign busy        = (state_q != LOAD);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - randomized directed bench with core/memory model for dot_product_sequencer
// Timeout scenario is compiled in when DP_TIMEOUT_EN is defined.
module tb_dot_product_sequencer;

  localparam int W  = 16;
  localparam int AW = 3;
  localparam int D  = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid, s_ready;
  logic [W-1:0]    s_real, s_imag;
  logic [4*W-1:0]  dp_inReal, dp_inImag;
  logic            dp_start, dp_done;
  logic [AW-1:0]   dp_readAddr;
  logic [W-1:0]    dp_readData;
  logic            m_valid, m_ready, m_last, busy, err;
  logic [W-1:0]    m_data;

  logic [W-1:0]    mem [D];
  logic [W-1:0]    op_re [4];
  logic [W-1:0]    op_im [4];
  logic            spur;
  logic            armed = 1'b0;
  int              since = 0;
  int              done_delay;
  int              cyc = 0;
  int              starts = 0;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  dot_product_sequencer #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .dp_inReal(dp_inReal), .dp_inImag(dp_inImag), .dp_start(dp_start), .dp_done(dp_done),
    .dp_readAddr(dp_readAddr), .dp_readData(dp_readData),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  // Core model: done rises done_delay cycles after the start cycle; memory read has one cycle latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dp_readData <= mem[dp_readAddr];
    if (dp_start) begin
      starts <= starts + 1;
      armed  <= 1'b1;
      since  <= 0;
    end else if (armed) begin
      since <= since + 1;
    end
  end
  assign dp_done = spur | (armed && (since >= done_delay - 1));

`ifndef DP_TIMEOUT_EN
  logic err_seen = 1'b0;
  always @(posedge clk) if (err) err_seen <= 1'b1;
`endif

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_job_data();
    for (int i = 0; i < 4; i++) begin
      op_re[i] = 16'($urandom);
      op_im[i] = 16'($urandom);
    end
    for (int k = 0; k < D; k++) mem[k] = 16'($urandom);
  endtask

  // Feeds the four operands; returns at the negedge of the START cycle.
  task automatic load_ops(input bit stall);
    int n;
    bit acc;
    for (int i = 0; i < 4; i++) begin
      if (!stall && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_real  = op_re[i];
      s_imag  = op_im[i];
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
        acc = s_ready;
        @(negedge clk);
        n++;
      end
      check("operand_accept", acc, 1);
    end
    if (stall) begin
      s_real = 16'($urandom);
      s_imag = 16'($urandom);
    end else begin
      s_valid = 1'b0;
    end
    check("start_pulse", dp_start, 1);
    check("ready_low_in_start", s_ready, 0);
    check("busy_in_start", busy, 1);
    check("in_real", dp_inReal, {op_re[3], op_re[2], op_re[1], op_re[0]});
    check("in_imag", dp_inImag, {op_im[3], op_im[2], op_im[1], op_im[0]});
  endtask

  task automatic run_job(input int dly, input int bp_word, input int bp_len,
                         input bit stall, input bit spur_en, input int rst_word);
    int n;
    int start_cyc;
    int starts0;
    done_delay = dly;
    starts0 = starts;
    spur = spur_en;
    load_ops(stall);
    start_cyc = cyc;
    @(negedge clk);
    spur = 1'b0;
    check("start_one_cycle", dp_start, 0);
    for (int k = 0; k < D; k++) begin
      n = 0;
      while (!m_valid && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("m_valid_arrives", m_valid, 1);
      if (k == 0) check("first_word_latency", cyc - start_cyc, dly + 3);
      check("m_data", m_data, mem[k]);
      check("m_last", m_last, (k == D - 1));
      check("read_addr", dp_readAddr, k);
      check("ready_low_in_out", s_ready, 0);
      if (k == rst_word) begin
        rst = 1'b1;
        #1;
        check("rst_outputs", {s_ready, dp_start, dp_readAddr, m_valid, m_data, m_last, busy, err}, 0);
        check("rst_operands", {dp_inReal, dp_inImag}, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_low_after_rst", s_ready, 0);
        @(negedge clk);
        check("ready_high_after_rst", s_ready, 1);
        check("no_start_after_rst", starts - starts0, 1);
        return;
      end
      if (k == bp_word) begin
        m_ready = 1'b0;
        repeat (bp_len) begin
          @(negedge clk);
          check("bp_valid_held", m_valid, 1);
          check("bp_data_held", m_data, mem[k]);
          check("bp_addr_held", dp_readAddr, k);
        end
        m_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_clears", m_valid, 0);
      if (k == D - 1) begin
        check("ready_after_job", s_ready, 1);
        check("idle_after_job", busy, 0);
      end else begin
        check("busy_mid_job", busy, 1);
      end
    end
    check("single_start", starts - starts0, 1);
  endtask

  initial begin
`ifdef DP_TIMEOUT_EN
    int n;
    int start_cyc;
    bit saw_mv;
`endif
    rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0;
    m_ready = 1'b1; spur = 1'b0; done_delay = 5;
    for (int k = 0; k < D; k++) mem[k] = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {s_ready, dp_start, dp_readAddr, m_valid, m_data, m_last, busy, err}, 0);
    check("reset_operands", {dp_inReal, dp_inImag}, 0);
    rst = 1'b0;
    #1;
    check("ready_low_at_release", s_ready, 0);
    @(negedge clk);
    check("ready_rises", s_ready, 1);
    check("idle_after_reset", busy, 0);

    op_re = '{16'd4, 16'd2, 16'd0, 16'd1};
    op_im = '{16'd1, 16'd3, 16'd0, 16'hFFFF};
    for (int k = 0; k < D; k++) mem[k] = 16'(3 * k);
    run_job(5, -1, 0, 1'b0, 1'b0, -1);
    run_job(5, 2, 3, 1'b0, 1'b0, -1);

    rand_job_data();
    run_job(4, -1, 0, 1'b1, 1'b0, -1);
    rand_job_data();
    run_job(6, -1, 0, 1'b1, 1'b0, -1);

    rand_job_data();
    run_job(3, -1, 0, 1'b0, 1'b1, -1);

    rand_job_data();
    run_job(5, -1, 0, 1'b0, 1'b0, 4);
    rand_job_data();
    run_job(5, -1, 0, 1'b0, 1'b0, -1);

    for (int j = 0; j < 6; j++) begin
      rand_job_data();
      run_job($urandom_range(2, 9), $urandom_range(0, D - 1), $urandom_range(1, 4),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

`ifdef DP_TIMEOUT_EN
    rand_job_data();
    done_delay = 1 << 30;
    spur = 1'b0;
    load_ops(1'b0);
    start_cyc = cyc;
    n = 0;
    saw_mv = 1'b0;
    while (!err && n < 100) begin
      @(negedge clk);
      saw_mv = saw_mv | m_valid;
      n++;
    end
    check("err_pulse", err, 1);
    check("err_time", cyc - start_cyc, TO + 1);
    check("no_words_on_timeout", saw_mv, 0);
    check("ready_after_timeout", s_ready, 1);
    @(negedge clk);
    check("err_one_cycle", err, 0);
`else
    check("err_never", err_seen, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
